imem_boot_loader: RTL

//  Boot-time loader upstream of the single-cycle core. Receives a program as a

---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_boot_loader_byte_packer.sv | 55 +++++
 rtl/imem_boot_loader.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM state
// encoding and the basic geometry of the incoming image (byte-wide stream,
// 32-bit words, 16-bit word-count header).
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_LOAD   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } loader_state_t;

    localparam int WORD_BYTES = 4;
    localparam int LEN_W      = 16;

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// byte_packer: collects four bytes, most significant first, into a 32-bit
// word and presents it with a one-cycle word_valid strobe on the cycle after
// the fourth byte arrives. The finished word stays on o_word afterwards so
// the memory data bus does not toggle between writes.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic [1:0]  o_cnt,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

    logic [23:0] r_shift;
    logic [1:0]  r_cnt;
    logic        r_word_valid;
    logic [31:0] r_word;

    // Shift bytes in; on the fourth byte publish the assembled word for one cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift      <= 24'h000000;
            r_cnt        <= 2'd0;
            r_word_valid <= 1'b0;
            r_word       <= 32'h00000000;
        end else if (i_clear) begin
            r_shift      <= 24'h000000;
            r_cnt        <= 2'd0;
            r_word_valid <= 1'b0;
        end else if (i_byte_valid) begin
            if (r_cnt == LAST_IDX) begin
                r_word       <= {r_shift, i_byte};
                r_word_valid <= 1'b1;
                r_shift      <= 24'h000000;
            end else begin
                r_shift      <= {r_shift[15:0], i_byte};
                r_word_valid <= 1'b0;
            end
            r_cnt <= r_cnt + 2'd1;
        end else begin
            r_word_valid <= 1'b0;
        end
    end

    assign o_cnt        = r_cnt;
    assign o_word_valid = r_word_valid;
    assign o_word       = r_word;

endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a program image over a byte valid/ready stream
// (16-bit big-endian word count, then the words big-endian), writes it into
// instruction memory from BASE_ADDR upwards and holds the core in reset until
// the whole image is in place.
// Optional build macro IMEM_LOADER_CHECKSUM_EN: the image is followed by one
// byte equal to the XOR of all payload bytes; a mismatch ends in the error state.
module imem_boot_loader
    import imem_loader_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = {ADDR_W{1'b0}},
    parameter int                DEPTH      = 256,
    parameter bit                AUTO_START = 1'b1
)
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    output logic              o_rx_ready,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [31:0]       o_wr_data,
    output logic              o_core_rst_n,
    output logic              o_done,
    output logic              o_err
);

    localparam logic [LEN_W:0]    DEPTH_L   = (LEN_W + 1)'(DEPTH);
    localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);
    localparam logic [1:0]        LAST_IDX  = 2'(WORD_BYTES - 1);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(WORD_BYTES);

    loader_state_t     r_state;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_word_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rx_ready;
    logic              r_done;
    logic              r_err;
    logic              r_core_rst_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    logic              w_accept;
    logic              w_restart;
    logic              w_pack_valid;
    logic [1:0]        w_pack_cnt;
    logic              w_word_valid;
    logic [31:0]       w_word;
    logic [LEN_W-1:0]  w_len_full;
    logic [LEN_W-1:0]  w_word_cnt_inc;
    logic              w_last_byte;

    assign w_accept       = i_rx_valid && r_rx_ready;
    assign w_restart      = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
    assign w_pack_valid   = w_accept && (r_state == ST_LOAD);
    assign w_len_full     = {r_len[LEN_W-1:8], i_rx_data};
    assign w_word_cnt_inc = r_word_cnt + LEN_ONE;
    // Fourth byte of the final word: stop accepting until the write has retired.
    assign w_last_byte    = w_pack_valid && (w_pack_cnt == LAST_IDX) && (r_word_cnt == (r_len - LEN_ONE));

    byte_packer u_packer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clear      (w_restart),
        .i_byte_valid (w_pack_valid),
        .i_byte       (i_rx_data),
        .o_cnt        (w_pack_cnt),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    // Loader FSM with its counters and all registered status outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= AUTO_START ? ST_LEN_HI : ST_IDLE;
            r_len        <= {LEN_W{1'b0}};
            r_word_cnt   <= {LEN_W{1'b0}};
            r_addr       <= BASE_ADDR;
            r_rx_ready   <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_core_rst_n <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum       <= 8'h00;
`endif
        end else if (w_restart) begin
            r_state      <= ST_LEN_HI;
            r_len        <= {LEN_W{1'b0}};
            r_word_cnt   <= {LEN_W{1'b0}};
            r_addr       <= BASE_ADDR;
            r_rx_ready   <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_core_rst_n <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum       <= 8'h00;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_rx_ready <= 1'b0;
                end
                ST_LEN_HI: begin
                    // Coming out of reset ready is still low; raise it here.
                    if (w_accept) begin
                        r_len   <= {i_rx_data, 8'h00};
                        r_state <= ST_LEN_LO;
                    end else begin
                        r_rx_ready <= 1'b1;
                    end
                end
                ST_LEN_LO: begin
                    if (w_accept) begin
                        r_len <= w_len_full;
                        if (w_len_full == {LEN_W{1'b0}}) begin
                            r_state      <= ST_DONE;
                            r_rx_ready   <= 1'b0;
                            r_done       <= 1'b1;
                            r_core_rst_n <= 1'b1;
                        end else if ({1'b0, w_len_full} > DEPTH_L) begin
                            r_state    <= ST_ERR;
                            r_rx_ready <= 1'b0;
                            r_err      <= 1'b1;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_last_byte) begin
                        r_rx_ready <= 1'b0;
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (w_pack_valid) begin
                        r_csum <= r_csum ^ i_rx_data;
                    end
`endif
                    if (w_word_valid) begin
                        r_word_cnt <= w_word_cnt_inc;
                        r_addr     <= r_addr + ADDR_STEP;
                        if (w_word_cnt_inc == r_len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_state    <= ST_CSUM;
                            r_rx_ready <= 1'b1;
`else
                            r_state      <= ST_DONE;
                            r_rx_ready   <= 1'b0;
                            r_done       <= 1'b1;
                            r_core_rst_n <= 1'b1;
`endif
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (w_accept) begin
                        r_rx_ready <= 1'b0;
                        if (i_rx_data == r_csum) begin
                            r_state      <= ST_DONE;
                            r_done       <= 1'b1;
                            r_core_rst_n <= 1'b1;
                        end else begin
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
`endif
                ST_DONE: begin
                    r_rx_ready <= 1'b0;
                end
                ST_ERR: begin
                    r_rx_ready <= 1'b0;
                end
                default: begin
                    // Unreachable encoding: park safely with the core held in reset.
                    r_state      <= ST_ERR;
                    r_rx_ready   <= 1'b0;
                    r_done       <= 1'b0;
                    r_err        <= 1'b1;
                    r_core_rst_n <= 1'b0;
                end
            endcase
        end
    end

    assign o_rx_ready   = r_rx_ready;
    assign o_wr_en      = w_word_valid;
    assign o_wr_addr    = r_addr;
    assign o_wr_data    = w_word;
    assign o_core_rst_n = r_core_rst_n;
    assign o_done       = r_done;
    assign o_err        = r_err;

endmodule
